// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and framebuffer geometry helpers for the VRAM arbiter
// and any logic that addresses the downscaled framebuffer (sprites, blitters).
package vram_arb_pkg;

  // Owner of the single VRAM port in a given cycle.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_WR   = 2'd2,
    OWN_RD   = 2'd3
  } owner_e;

  // Framebuffer dimension after downscaling one display axis.
  function automatic int unsigned fb_dim(input int unsigned disp, input int unsigned shift);
    return disp >> shift;
  endfunction

  // FB_W/FB_H for a given display geometry.
  function automatic int unsigned fb_w(input int unsigned h_disp, input int unsigned shift);
    return fb_dim(h_disp, shift);
  endfunction

  function automatic int unsigned fb_h(input int unsigned v_disp, input int unsigned shift);
    return fb_dim(v_disp, shift);
  endfunction

  // Total framebuffer entries (FB_SIZE).
  function automatic int unsigned fb_size(input int unsigned h_disp, input int unsigned v_disp,
                                          input int unsigned shift);
    return fb_w(h_disp, shift) * fb_h(v_disp, shift);
  endfunction

  // Colour channel layout: {red, green, blue}, equal-width channels.
  function automatic int unsigned col_width(input int unsigned pix_width);
    return pix_width / 3;
  endfunction

  function automatic int unsigned red_lsb(input int unsigned pix_width);
    return 2 * (pix_width / 3);
  endfunction

  function automatic int unsigned green_lsb(input int unsigned pix_width);
    return pix_width / 3;
  endfunction

  function automatic int unsigned blue_lsb(input int unsigned pix_width);
    return 0 * pix_width;
  endfunction

endpackage

// File: rtl/vram_addr_map.sv
// vram_addr_map: combinational screen-position to framebuffer-address mapper.
// Ports:
//   hpos, vpos : screen coordinates from the timing generator
//   addr       : (vpos>>PIX_SHIFT)*FB_W + (hpos>>PIX_SHIFT)
module vram_addr_map
  import vram_arb_pkg::*;
#(
  parameter int unsigned HPOS_WIDTH = 10,
  parameter int unsigned VPOS_WIDTH = 10,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned PIX_SHIFT  = 2,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned FB_W = fb_w(H_DISPLAY, PIX_SHIFT);

  logic [HPOS_WIDTH-1:0] col;
  logic [VPOS_WIDTH-1:0] row;

  // Truncate to framebuffer resolution before the constant multiply.
  assign col  = hpos >> PIX_SHIFT;
  assign row  = vpos >> PIX_SHIFT;
  assign addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(FB_W) + ADDR_WIDTH'(col);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port, 1-cycle-latency VRAM between display
// scanout (absolute priority on phase 0 of every active pixel) and a pixel
// writer, and re-times hsync/vsync to stay aligned with the fetched RGB.
// Optional readback port: define VRAM_READBACK_EN.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   hpos, vpos, display_on, hsync/vsync: from the 640x480 timing generator
//   vga_hsync, vga_vsync, vga_rgb      : to the VGA pins, one pixel (2 clk) late
//   mem_addr, mem_we, mem_wdata        : VRAM command (combinational per slot)
//   mem_rdata                          : VRAM read data, one cycle after address
//   wr_valid, wr_ready, wr_addr, wr_data: writer handshake
//   rd_valid, rd_ready, rd_addr, rd_data, rd_data_valid: readback (VRAM_READBACK_EN)
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned HPOS_WIDTH = 10,
  parameter int unsigned VPOS_WIDTH = 10,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned PIX_SHIFT  = 2,
  parameter int unsigned PIX_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  input  logic                  display_on,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [PIX_WIDTH-1:0]  vga_rgb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [PIX_WIDTH-1:0]  mem_wdata,
  input  logic [PIX_WIDTH-1:0]  mem_rdata,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [PIX_WIDTH-1:0]  wr_data
`ifdef VRAM_READBACK_EN
  ,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PIX_WIDTH-1:0]  rd_data,
  output logic                  rd_data_valid
`endif
);

  localparam int unsigned FB_SIZE = fb_size(H_DISPLAY, V_DISPLAY, PIX_SHIFT);
  localparam logic [ADDR_WIDTH-1:0] FB_LIMIT = ADDR_WIDTH'(FB_SIZE);

  logic                  phase;
  logic                  phase_nxt;
  owner_e                owner;
  logic                  writer_slot;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  disp_q;
  logic                  hs_q;
  logic                  vs_q;

`ifdef VRAM_READBACK_EN
  logic rr_rd;     // 1: readback has priority on the next contended slot
  logic rd_pend;   // readback address was presented last cycle
  logic rd_oob_q;  // that address was outside the framebuffer
`endif

  vram_addr_map #(
    .HPOS_WIDTH (HPOS_WIDTH),
    .VPOS_WIDTH (VPOS_WIDTH),
    .H_DISPLAY  (H_DISPLAY),
    .PIX_SHIFT  (PIX_SHIFT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_map (
    .hpos (hpos),
    .vpos (vpos),
    .addr (disp_addr)
  );

  // Phase register: tracks the timing generator's divide-by-2 pixel enable.
  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= phase_nxt;
  end

  // Next phase and slot owner for this cycle.
  always_comb begin
    phase_nxt   = ~phase;
    owner       = OWN_IDLE;
    writer_slot = 1'b0;
    if (!reset) begin
      if (!phase && display_on) begin
        owner = OWN_DISP;
      end else begin
        writer_slot = 1'b1;
`ifdef VRAM_READBACK_EN
        if (wr_valid && (!rd_valid || !rr_rd)) owner = OWN_WR;
        else if (rd_valid)                     owner = OWN_RD;
`else
        if (wr_valid) owner = OWN_WR;
`endif
      end
    end
  end

  // VRAM command and handshake outputs for the current owner.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
`ifdef VRAM_READBACK_EN
    wr_ready  = (owner == OWN_WR);
    rd_ready  = (owner == OWN_RD);
`else
    wr_ready  = writer_slot;
`endif
    unique case (owner)
      OWN_DISP: mem_addr = disp_addr;
      OWN_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        // Out-of-range writes are consumed but never reach the RAM.
        mem_we    = (wr_addr < FB_LIMIT);
      end
`ifdef VRAM_READBACK_EN
      OWN_RD:   mem_addr = rd_addr;
`endif
      default: ;
    endcase
  end

  // Scanout pipeline: capture controls with the read, emit once data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      vga_rgb   <= '0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else if (!phase) begin
      disp_q <= display_on;
      hs_q   <= hsync;
      vs_q   <= vsync;
    end else begin
      vga_rgb   <= disp_q ? mem_rdata : '0;
      vga_hsync <= hs_q;
      vga_vsync <= vs_q;
    end
  end

`ifdef VRAM_READBACK_EN
  // Readback arbitration pointer and two-stage response pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_rd         <= 1'b0;
      rd_pend       <= 1'b0;
      rd_oob_q      <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      if (writer_slot && wr_valid && rd_valid) rr_rd <= ~rr_rd;
      rd_pend       <= (owner == OWN_RD);
      rd_oob_q      <= (rd_addr >= FB_LIMIT);
      rd_data_valid <= rd_pend;
      if (rd_pend) rd_data <= rd_oob_q ? '0 : mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: timing generator, VRAM and writer models with a
// per-cycle reference check plus literal spot checks.
module tb_vram_arbiter;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_SIZE = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on, hsync, vsync;
  logic        vga_hsync, vga_vsync;
  logic [11:0] vga_rgb;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata, mem_rdata;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
`ifdef VRAM_READBACK_EN
  logic        rd_valid = 1'b0;
  logic        rd_ready, rd_data_valid;
  logic [14:0] rd_addr = '0;
  logic [11:0] rd_data;
`endif

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_rgb    (vga_rgb),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`ifdef VRAM_READBACK_EN
    ,
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid)
`endif
  );

  // VRAM: single port, read data one cycle after the address.
  logic [11:0] ram [0:32767];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Reference framebuffer, updated from the writer transfers the rules allow.
  logic [11:0] ref_fb [0:FB_SIZE-1];

  typedef struct packed {
    logic        disp;
    logic        hs;
    logic        vs;
    logic [11:0] pix;
  } rec_t;
  rec_t h0 = '0, h1 = '0, h2 = '0;  // pixel/sync history: now, 1 clk ago, 2 clk ago

  typedef struct packed {
    logic [14:0] a;
    logic [11:0] d;
  } wreq_t;
  wreq_t wq[$];

  int   hc = 0, vc = 0;
  logic ph = 1'b0;
  int   jump_v = 0;
  bit   jump_req = 1'b0;
  bit   rst_next = 1'b1;
  bit   chk_en = 1'b0;
  logic        exp_ready = 1'b0, exp_we = 1'b0;
  logic [14:0] exp_addr = '0;
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_gen();
    hpos       = 10'(hc);
    vpos       = 10'(vc);
    display_on = (hc < 640) && (vc < 480);
    hsync      = !((hc >= 656) && (hc < 752));
    vsync      = !((vc >= 490) && (vc < 492));
  endtask

  // Advance the environment by one clock edge (called just after posedge).
  task automatic step();
    if (wr_valid && exp_ready) begin
      if (wq[0].a < 15'(FB_SIZE)) ref_fb[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
    h2 = h1;
    h1 = h0;
    if (reset) begin
      hc = 0; vc = 0; ph = 1'b0;
      h1 = '0; h2 = '0;
    end else begin
      if (ph) begin
        hc++;
        if (hc == 800) begin
          hc = 0;
          vc++;
          if (vc == 525) vc = 0;
        end
      end
      ph = !ph;
    end
    if (jump_req && !ph) begin
      hc = 0; vc = jump_v; jump_req = 1'b0;
    end
    reset = rst_next;
    drive_gen();
    wr_valid = (wq.size() > 0);
    if (wr_valid) begin
      wr_addr = wq[0].a;
      wr_data = wq[0].d;
    end
`ifdef VRAM_READBACK_EN
    exp_ready = !reset && (ph || !display_on) && wr_valid;
`else
    exp_ready = !reset && (ph || !display_on);
`endif
    exp_we = exp_ready && wr_valid && (wr_addr < 15'(FB_SIZE));
    if (!reset && !ph && display_on) exp_addr = 15'((vc / 4) * FB_W + hc / 4);
    else if (exp_ready && wr_valid)  exp_addr = wr_addr;
    else                             exp_addr = '0;
    if (reset) h0 = '0;
    else begin
      h0.disp = display_on;
      h0.hs   = hsync;
      h0.vs   = vsync;
      h0.pix  = display_on ? ref_fb[(vc / 4) * FB_W + hc / 4] : 12'h000;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("vga_rgb",   32'(vga_rgb),   32'(h2.pix));
      chk("vga_hsync", 32'(vga_hsync), 32'(h2.hs));
      chk("vga_vsync", 32'(vga_vsync), 32'(h2.vs));
      chk("wr_ready",  32'(wr_ready),  32'(exp_ready));
      chk("mem_we",    32'(mem_we),    32'(exp_we));
      chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = (i < FB_SIZE) ? 12'(i * 7 + 3) : 12'h000;
    for (int i = 0; i < FB_SIZE; i++) ref_fb[i] = 12'(i * 7 + 3);
    ram[0] = 12'hF00; ref_fb[0] = 12'hF00;
    ram[1] = 12'h0F0; ref_fb[1] = 12'h0F0;
    reset = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    drive_gen();

    // Reset held for three cycles.
    run(1);
    chk_en = 1'b1;
    run(2);
    @(negedge clk);
    chk("rst_vga_rgb", 32'(vga_rgb), 32'h0);
    chk("rst_mem_we",  32'(mem_we),  32'h0);

    // Release reset with writes pending into row 0 of the framebuffer.
    rst_next = 1'b0;
    for (int i = 0; i < 24; i++) wq.push_back({15'(10 + i), 12'(i * 273 + 5)});
    for (int t = 0; t < 18; t++) begin
      run(1);
      @(negedge clk);
      if (t == 0) chk("first_cycle_display_slot", 32'(wr_ready), 32'h0);
      if (t == 1) chk("second_cycle_writer_slot", 32'(wr_ready), 32'h1);
      if (t == 2 || t == 9)  chk("scan_pixels_0_3", 32'(vga_rgb), 32'hF00);
      if (t == 10 || t == 17) chk("scan_pixels_4_7", 32'(vga_rgb), 32'h0F0);
    end

    // Horizontal blanking on line 0: writer owns every cycle.
    run(1383);
    for (int k = 0; k < 6; k++) wq.push_back({15'(50 + k), 12'(12'hA00 + k)});
    wq.push_back({15'(FB_SIZE), 12'hABC});
    wq.push_back({15'(60), 12'h5A5});
    run(1);
    @(negedge clk);
    chk("blank_ready_a", 32'(wr_ready), 32'h1);
    run(1);
    @(negedge clk);
    chk("blank_ready_b", 32'(wr_ready), 32'h1);
    for (int k = 0; k < 20 && !(wr_valid && wr_addr == 15'(FB_SIZE)); k++) run(1);
    @(negedge clk);
    chk("oob_ready", 32'(wr_ready), 32'h1);
    chk("oob_mem_we", 32'(mem_we), 32'h0);
    run(4);
    chk("oob_ram_untouched", 32'(ram[FB_SIZE]), 32'h0);
    chk("line0_write_landed", 32'(ram[12]), 32'h227);
    chk("blank_write_landed", 32'(ram[60]), 32'h5A5);

    // Finish lines 1 and 2, then jump near the frame end and run across vsync.
    for (int k = 0; k < 5000 && !(vc == 3 && hc == 0); k++) run(1);
    jump_v = 488;
    jump_req = 1'b1;
    run(2);
    for (int k = 0; k < 70000 && !(vc == 0 && hc == 200); k++) run(1);

    // Reset mid-line: output blanked on the very next cycle.
    rst_next = 1'b1;
    run(1);
    rst_next = 1'b0;
    run(1);
    @(negedge clk);
    chk("midline_reset_rgb", 32'(vga_rgb), 32'h0);
    run(40);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
